instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage feeding the decode/control path.
- Holds the PC and fetches one instruction word from a variable-latency instruction memory over a req/ack handshake.
- Presents the instruction and its opcode field to the control unit, then waits for the execute side to signal completion.
- Computes the next PC from the resolved branch/jump controls and the ALU zero flag.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- BNE_OPCODE, 6'b100111, opcode whose branch condition is inverted (taken when zero=0).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- imemReq  output  1  instruction memory request, level, held until ack
- imemAddr  output  32  byte address of the requested word; equals pc
- imemAck  input  1  memory has valid data on imemData this cycle
- imemData  input  32  instruction word, sampled when imemReq & imemAck
- instr  output  32  latched instruction
- opcode  output  6  instr[31:26], to control unit
- instrValid  output  1  instr is valid and awaiting execution
- instrDone  input  1  execute side has finished instr this cycle
- branch  input  1  control unit branch, sampled with instrDone
- jump  input  1  control unit jump, sampled with instrDone
- aluZero  input  1  ALU zero flag, sampled with instrDone
- pc  output  32  address of current instruction
- pcPlus4  output  32  pc + 4, for link write (jal)

Behaviour:
- State machine has three states: S_IDLE, S_FETCH, S_EXEC.
- Reset, sampled at a rising edge:
  - state=S_IDLE, pc=RESET_PC, instr=0, instrValid=0, imemReq=0.
  - Reset overrides everything, including an outstanding request or an executing instruction. Any ack arriving in the reset cycle is dropped.
- S_IDLE:
  - Lasts exactly one cycle.
  - Next state is S_FETCH.
- S_FETCH:
  - imemReq=1, imemAddr=pc.
  - On imemReq & imemAck: instr<=imemData and state<=S_EXEC.
  - Ack may arrive in the first S_FETCH cycle. The minimum is then one S_FETCH cycle, with instrValid high on the next cycle.
  - With no ack, the block stays in S_FETCH, holding imemReq and imemAddr stable.
- S_EXEC:
  - instrValid=1, imemReq=0.
  - instr, opcode and pc stay stable until instrDone.
  - On instrDone, pc<=nextPc and state<=S_FETCH. The next request is issued in the following cycle.
- Output decoding:
  - instrValid and imemReq are decoded from state. Both are 0 in S_IDLE.
- Ignored inputs:
  - imemAck outside S_FETCH has no effect.
  - instrDone, branch, jump and aluZero outside S_EXEC have no effect.
- Next-PC arithmetic (all modulo 2^32):
  - pcPlus4 = pc + 4. Wrap-around is allowed: 32'hFFFF_FFFC + 4 = 0.
  - brTarget = pcPlus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), i.e. a sign-extended offset in words.
  - jTarget = {pcPlus4[31:28], instr[25:0], 2'b00}.
  - brCond = aluZero when opcode != BNE_OPCODE; brCond = ~aluZero when opcode == BNE_OPCODE.
- Next-PC priority:
  - jump=1 gives nextPc = jTarget, regardless of branch.
  - Else branch & brCond gives nextPc = brTarget.
  - Else nextPc = pcPlus4.
- pc[1:0] is always 0. Target computations cannot produce non-zero low bits.
- No speculation: exactly one outstanding request at a time, and no fetch while an instruction is executing.

Test Plan:
- Reset / sequential fetch:
  - Stimulus: RESET_PC=0, ack one cycle after each req; imem returns R-type 32'h0000_0020, then 32'h0800_0001 (ADD_IMM); instrDone one cycle after instrValid.
  - Required response: imemAddr sequence 0, 4, 8; opcode 6'b000000, then 6'b000010; imemReq=0 in the cycle after reset.
- Variable latency:
  - Stimulus: ack delayed 5 cycles.
  - Required response: imemReq and imemAddr held for 5 cycles; instrValid rises the cycle after ack; a spurious ack while in S_EXEC leaves instr unchanged.
- Branch equal:
  - Stimulus: pc=32'h10, instr opcode 6'b100011 with imm=16'hFFFE, branch=1, aluZero=1.
  - Required response: next imemAddr=32'h0C.
  - With aluZero=0: next imemAddr=32'h14.
- Branch not equal:
  - Stimulus: opcode 6'b100111, imm=16'h0003, pc=32'h20.
  - Required response: aluZero=0 gives 32'h30; aluZero=1 gives 32'h24.
- Jump priority / jal:
  - Stimulus: pc=32'h4000_0000, instr={6'b111001, 26'h0000_0FA}, jump=1 and branch=1.
  - Required response: nextPc=32'h4000_03E8; pcPlus4=32'h4000_0004 during S_EXEC.
- Reset mid-operation and wrap:
  - Stimulus: reset asserted in S_FETCH with ack in the same cycle.
  - Required response: instr=0, pc=RESET_PC, and a new request after S_IDLE.
  - Stimulus: pc=32'hFFFF_FFFC, sequential instrDone.
  - Required response: next imemAddr=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, req/ack instruction fetch, next-PC selection
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [5:0]  BNE_OPCODE = 6'b100111
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemAck,
   input  logic [31:0] imemData,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic        instrValid,
   input  logic        instrDone,
   input  logic        branch,
   input  logic        jump,
   input  logic        aluZero,
   output logic [31:0] pc,
   output logic [31:0] pcPlus4
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] br_offset;
   logic [31:0] br_target;
   logic [31:0] j_target;
   logic [31:0] next_pc;
   logic        br_cond;

   assign imemAddr = pc;
   assign opcode   = instr[31:26];

   always_comb begin
      pcPlus4   = pc + 32'd4;
      br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
      br_target = pcPlus4 + br_offset;
      j_target  = {pcPlus4[31:28], instr[25:0], 2'b00};
      br_cond   = (opcode == BNE_OPCODE) ? ~aluZero : aluZero;
      // jump wins over branch even when both are asserted
      if (jump) begin
         next_pc = j_target;
      end else if (branch && br_cond) begin
         next_pc = br_target;
      end else begin
         next_pc = pcPlus4;
      end
   end

   // imemReq and instrValid are registered alongside the state so they track it exactly
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         pc         <= {RESET_PC[31:2], 2'b00};
         instr      <= 32'h0;
         instrValid <= 1'b0;
         imemReq    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state      <= S_FETCH;
               imemReq    <= 1'b1;
               instrValid <= 1'b0;
            end
            S_FETCH: begin
               if (imemAck) begin
                  instr      <= imemData;
                  state      <= S_EXEC;
                  imemReq    <= 1'b0;
                  instrValid <= 1'b1;
               end
            end
            S_EXEC: begin
               if (instrDone) begin
                  pc         <= {next_pc[31:2], 2'b00};
                  state      <= S_FETCH;
                  imemReq    <= 1'b1;
                  instrValid <= 1'b0;
               end
            end
            default: begin
               state      <= S_IDLE;
               imemReq    <= 1'b0;
               instrValid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - table-driven and randomized checks of instr_fetch_unit
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imemAck;
   logic [31:0] imemData;
   logic        instrDone;
   logic        branch;
   logic        jump;
   logic        aluZero;

   logic        imemReq,    hi_imemReq;
   logic [31:0] imemAddr,   hi_imemAddr;
   logic [31:0] instr,      hi_instr;
   logic [5:0]  opcode,     hi_opcode;
   logic        instrValid, hi_instrValid;
   logic [31:0] pc,         hi_pc;
   logic [31:0] pcPlus4,    hi_pcPlus4;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk(clk), .reset(reset),
      .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
      .instr(instr), .opcode(opcode), .instrValid(instrValid), .instrDone(instrDone),
      .branch(branch), .jump(jump), .aluZero(aluZero), .pc(pc), .pcPlus4(pcPlus4)
   );

   // Same stimulus, high reset address; control flow is identical so it runs in lockstep
   instr_fetch_unit #(.RESET_PC(32'h4000_0000)) dut_hi (
      .clk(clk), .reset(reset),
      .imemReq(hi_imemReq), .imemAddr(hi_imemAddr), .imemAck(imemAck), .imemData(imemData),
      .instr(hi_instr), .opcode(hi_opcode), .instrValid(hi_instrValid), .instrDone(instrDone),
      .branch(branch), .jump(jump), .aluZero(aluZero), .pc(hi_pc), .pcPlus4(hi_pcPlus4)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          lat;
      logic        br;
      logic        jmp;
      logic        z;
      logic [31:0] nxt;
      logic [5:0]  op;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                              input logic br, input logic jmp, input logic z);
      logic [31:0] p4;
      int          off;
      logic        cond;
      p4   = cur + 32'd4;
      off  = $signed(w[15:0]);
      cond = ((w >> 26) == 32'd39) ? !z : z;
      if (jmp) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
      if (br && cond) return p4 + 32'(off * 4);
      return p4;
   endfunction

   task automatic do_instr(input logic [31:0] addr, input logic [31:0] data, input int lat,
                           input int dly, input logic br, input logic jmp, input logic z,
                           input logic [31:0] nxt, input logic [5:0] op, input logic chk_hi);
      int cnt = 0;
      while (!imemReq && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("req_timeout", imemReq, 1'b1);
      chk("fetch_addr", imemAddr, addr);
      for (int i = 0; i < lat; i++) begin
         imemAck   = 1'b0;
         instrDone = 1'($urandom);
         branch    = 1'($urandom);
         jump      = 1'($urandom);
         aluZero   = 1'($urandom);
         @(negedge clk);
         chk("req_held", imemReq, 1'b1);
         chk("addr_held", imemAddr, addr);
         chk("no_valid_in_fetch", instrValid, 1'b0);
      end
      imemAck   = 1'b1;
      imemData  = data;
      instrDone = 1'b0;
      @(negedge clk);
      imemAck  = 1'b0;
      imemData = $urandom;
      chk("valid_after_ack", instrValid, 1'b1);
      chk("req_low_exec", imemReq, 1'b0);
      chk("instr", instr, data);
      chk("opcode", 32'(opcode), 32'(op));
      chk("pcplus4", pcPlus4, addr + 32'd4);
      if (chk_hi) chk("hi_pcplus4", hi_pcPlus4, 32'h4000_0004);
      for (int i = 0; i < dly; i++) begin
         imemAck  = 1'b1;
         imemData = ~data;
         branch   = 1'($urandom);
         jump     = 1'($urandom);
         aluZero  = 1'($urandom);
         @(negedge clk);
         imemAck = 1'b0;
         chk("spurious_ack_instr", instr, data);
         chk("exec_pc_stable", pc, addr);
         chk("exec_valid_held", instrValid, 1'b1);
      end
      instrDone = 1'b1;
      branch    = br;
      jump      = jmp;
      aluZero   = z;
      @(negedge clk);
      instrDone = 1'b0;
      chk("next_req", imemReq, 1'b1);
      chk("valid_drop", instrValid, 1'b0);
      chk("next_addr", imemAddr, nxt);
      if (chk_hi) chk("hi_next_addr", hi_imemAddr, 32'h4000_03E8);
   endtask

   task automatic mid_reset();
      imemAck  = 1'b1;
      imemData = 32'hDEAD_BEEF;
      reset    = 1'b1;
      @(negedge clk);
      reset   = 1'b0;
      imemAck = 1'b0;
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_req", imemReq, 1'b0);
      chk("rst_valid", instrValid, 1'b0);
      @(negedge clk);
      chk("post_idle_req", imemReq, 1'b1);
      chk("post_idle_addr", imemAddr, 32'h0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] m_pc;
      logic [31:0] w;
      logic        br, jmp, z;

      tbl[0]  = '{32'h0000_0000, 32'h0000_0020, 1, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 6'b000000};
      tbl[1]  = '{32'h0000_0004, 32'h0800_0001, 1, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 6'b000010};
      tbl[2]  = '{32'h0000_0008, 32'h8C00_0001, 5, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 6'b100011};
      tbl[3]  = '{32'h0000_0010, 32'h8C00_FFFE, 0, 1'b1, 1'b0, 1'b1, 32'h0000_000C, 6'b100011};
      tbl[4]  = '{32'h0000_000C, 32'h8C00_0000, 2, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 6'b100011};
      tbl[5]  = '{32'h0000_0010, 32'h8C00_FFFE, 1, 1'b1, 1'b0, 1'b0, 32'h0000_0014, 6'b100011};
      tbl[6]  = '{32'h0000_0014, 32'h8C00_0002, 1, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 6'b100011};
      tbl[7]  = '{32'h0000_0020, 32'h9C00_0003, 1, 1'b1, 1'b0, 1'b0, 32'h0000_0030, 6'b100111};
      tbl[8]  = '{32'h0000_0030, 32'h8C00_FFFB, 3, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 6'b100011};
      tbl[9]  = '{32'h0000_0020, 32'h9C00_0003, 1, 1'b1, 1'b0, 1'b1, 32'h0000_0024, 6'b100111};
      tbl[10] = '{32'h0000_0024, 32'hE400_00FA, 1, 1'b1, 1'b1, 1'b1, 32'h0000_03E8, 6'b111001};
      tbl[11] = '{32'h0000_03E8, 32'h8C00_FFFE, 1, 1'b0, 1'b0, 1'b1, 32'h0000_03EC, 6'b100011};

      reset     = 1'b1;
      imemAck   = 1'b0;
      imemData  = 32'h0;
      instrDone = 1'b0;
      branch    = 1'b0;
      jump      = 1'b0;
      aluZero   = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_req", imemReq, 1'b0);
      chk("reset_valid", instrValid, 1'b0);
      chk("reset_instr", instr, 32'h0);
      chk("reset_pc", pc, 32'h0);
      chk("reset_hi_pc", hi_pc, 32'h4000_0000);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++)
         do_instr(tbl[i].addr, tbl[i].data, tbl[i].lat, 1, tbl[i].br, tbl[i].jmp,
                  tbl[i].z, tbl[i].nxt, tbl[i].op, 1'b0);

      mid_reset();
      do_instr(32'h0, 32'hE400_00FA, 1, 1, 1'b1, 1'b1, 1'b1, 32'h0000_03E8, 6'b111001, 1'b1);

      mid_reset();
      do_instr(32'h0, 32'h8C00_FFFE, 0, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 6'b100011, 1'b0);
      do_instr(32'hFFFF_FFFC, 32'h0000_0020, 1, 0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0);

      m_pc = 32'h0;
      for (int n = 0; n < 40; n++) begin
         w   = $urandom;
         if (n % 3 == 0) w[31:26] = 6'b100111;
         br  = 1'($urandom);
         jmp = ($urandom_range(0, 3) == 0);
         z   = 1'($urandom);
         do_instr(m_pc, w, $urandom_range(0, 3), $urandom_range(0, 2), br, jmp, z,
                  model_next(m_pc, w, br, jmp, z), w[31:26], 1'b0);
         m_pc = model_next(m_pc, w, br, jmp, z);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
